// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and defaults for the MEM-stage data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int ERR_ADDR_W = 30;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, clocked write and combinational read, no reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int IW = $clog2(DEPTH_WORDS)
) (
  input  logic          Clk,
  input  logic          We,
  input  logic [IW-1:0] Index,
  input  logic [31:0]   WData,
  output logic [31:0]   RData
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge Clk)
    if (We) mem[Index] <= WData;
  assign RData = mem[Index];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder that stalls the pipeline while busy.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Req_Ready,
  output logic        Resp_Valid,
  output logic [31:0] Resp_RData,
  output logic        Resp_Error,
  output logic        Stall
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic wr_q;
  logic [31:0] addr_q, wdata_q;
  logic idle, acc, cur_wr, err, enter_resp, we;
  logic [31:0] cur_addr, cur_wdata, ram_rdata;
  // With LATENCY==1 the request goes straight to RESP, so the live request fields feed the RAM.
  always_comb begin
    idle = state == IDLE;
    acc = idle && Req_Valid;
    cur_wr = idle ? Req_Write : wr_q;
    cur_addr = idle ? Req_Addr : addr_q;
    cur_wdata = idle ? Req_WData : wdata_q;
    err = cur_addr[1:0] != 2'b0 || cur_addr[31:2] >= ERR_ADDR_W'(DEPTH_WORDS);
    state_nx = idle ? (Req_Valid ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
             : state == BUSY ? (cnt == 4'd1 ? RESP : BUSY) : IDLE;
    cnt_nx = acc ? 4'(LATENCY - 1) : state == BUSY ? cnt - 4'd1 : cnt;
    enter_resp = state_nx == RESP && state != RESP;
    we = enter_resp && cur_wr && !err && !Rst;
    Req_Ready = idle;
    Resp_Valid = state == RESP;
    Stall = acc || state == BUSY;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      Resp_RData <= 32'd0;
      Resp_Error <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (acc) begin
        wr_q <= Req_Write;
        addr_q <= Req_Addr;
        wdata_q <= Req_WData;
      end
      if (enter_resp) begin
        Resp_Error <= err;
        Resp_RData <= (cur_wr || err) ? 32'd0 : ram_rdata;
      end
    end
  end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .Clk  (Clk),
    .We   (we),
    .Index(cur_addr[IW+1:2]),
    .WData(cur_wdata),
    .RData(ram_rdata)
  );
endmodule
